// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one datapath.
// One step walks every neuron once, then publishes the spike vector with a one-cycle pulse.
module lif_neuron_array #(
  parameter int unsigned N_CHANNEL    = 4,
  parameter int unsigned N_NEURON     = 8,
  parameter int unsigned W_WIDTH      = 8,
  parameter int unsigned V_WIDTH      = 16,
  parameter int unsigned LEAK_WIDTH   = 5,
  parameter int unsigned REFRAC_WIDTH = 4,
  parameter logic signed [V_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned CH_AW = (N_CHANNEL > 1) ? $clog2(N_CHANNEL) : 1,
  parameter int unsigned NR_AW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step_valid,
  output logic                      step_ready,
  input  logic [N_CHANNEL-1:0]      spike_in,
  input  logic [LEAK_WIDTH-1:0]     leak_shift,
  input  logic [V_WIDTH-1:0]        threshold,
  input  logic [REFRAC_WIDTH-1:0]   refrac_len,
  input  logic                      weight_wr,
  input  logic [NR_AW+CH_AW-1:0]    weight_addr,
  input  logic [W_WIDTH-1:0]        weight_data,
  output logic [N_NEURON-1:0]       spike_out,
  output logic                      spike_valid,
  input  logic [NR_AW-1:0]          vmem_rd_addr,
  output logic [V_WIDTH-1:0]        vmem_rd_data
);

  // Wide enough that V - L + I cannot overflow before saturation.
  localparam int unsigned SW = V_WIDTH + CH_AW + 2;

  typedef enum logic [1:0] {StIdle, StUpdate, StDone} state_e;

  state_e                    state_q;
  logic [NR_AW-1:0]          n_q;
  logic [N_CHANNEL-1:0]      spk_q;
  logic [LEAK_WIDTH-1:0]     leak_q;
  logic signed [V_WIDTH-1:0] thr_q;
  logic [REFRAC_WIDTH-1:0]   rlen_q;
  logic [N_NEURON-1:0]       acc_q;

  logic signed [W_WIDTH-1:0]  w_q      [N_NEURON][N_CHANNEL];
  logic signed [V_WIDTH-1:0]  v_q      [N_NEURON];
  logic [REFRAC_WIDTH-1:0]    refrac_q [N_NEURON];

  logic signed [V_WIDTH-1:0] v_cur;
  logic signed [V_WIDTH-1:0] l_val;
  logic signed [V_WIDTH-1:0] s_sat;
  logic signed [SW-1:0]      i_sum;
  logic signed [SW-1:0]      s_wide;
  logic                      fire;
  logic                      refrac_busy;

  always_comb begin
    v_cur = v_q[n_q];
    i_sum = '0;
    for (int c = 0; c < N_CHANNEL; c++) begin
      if (spk_q[c]) begin
        i_sum = i_sum + $signed({{(SW-W_WIDTH){w_q[n_q][c][W_WIDTH-1]}}, w_q[n_q][c]});
      end
    end
    if (32'(leak_q) >= V_WIDTH) begin
      l_val = '0;
    end else begin
      l_val = v_cur >>> leak_q;
    end
    s_wide = $signed({{(SW-V_WIDTH){v_cur[V_WIDTH-1]}}, v_cur})
           - $signed({{(SW-V_WIDTH){l_val[V_WIDTH-1]}}, l_val})
           + i_sum;
    // Out of range when the bits above the V_WIDTH sign bit disagree with it.
    if (s_wide[SW-1:V_WIDTH-1] != {(SW-V_WIDTH+1){s_wide[SW-1]}}) begin
      s_sat = s_wide[SW-1] ? {1'b1, {(V_WIDTH-1){1'b0}}} : {1'b0, {(V_WIDTH-1){1'b1}}};
    end else begin
      s_sat = s_wide[V_WIDTH-1:0];
    end
    fire        = (s_sat >= thr_q);
    refrac_busy = (refrac_q[n_q] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      n_q          <= '0;
      spk_q        <= '0;
      leak_q       <= '0;
      thr_q        <= '0;
      rlen_q       <= '0;
      acc_q        <= '0;
      step_ready   <= 1'b1;
      spike_out    <= '0;
      spike_valid  <= 1'b0;
      vmem_rd_data <= '0;
      for (int k = 0; k < N_NEURON; k++) begin
        v_q[k]      <= RESET_VALUE;
        refrac_q[k] <= '0;
      end
    end else begin
      spike_valid  <= 1'b0;
      vmem_rd_data <= v_q[vmem_rd_addr];
      unique case (state_q)
        StIdle: begin
          if (step_valid) begin
            spk_q      <= spike_in;
            leak_q     <= leak_shift;
            thr_q      <= threshold;
            rlen_q     <= refrac_len;
            n_q        <= '0;
            acc_q      <= '0;
            step_ready <= 1'b0;
            state_q    <= StUpdate;
          end
        end
        StUpdate: begin
          if (refrac_busy) begin
            refrac_q[n_q] <= refrac_q[n_q] - 1'b1;
          end else if (fire) begin
            acc_q[n_q]    <= 1'b1;
            v_q[n_q]      <= RESET_VALUE;
            refrac_q[n_q] <= rlen_q;
          end else begin
            v_q[n_q] <= s_sat;
          end
          if (n_q == NR_AW'(N_NEURON - 1)) begin
            state_q <= StDone;
          end else begin
            n_q <= n_q + 1'b1;
          end
        end
        StDone: begin
          spike_out   <= acc_q;
          spike_valid <= 1'b1;
          step_ready  <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Registered weights: a write lands after the current neuron's update has used the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_NEURON; k++) begin
        for (int c = 0; c < N_CHANNEL; c++) begin
          w_q[k][c] <= '0;
        end
      end
    end else if (weight_wr) begin
      w_q[weight_addr[NR_AW+CH_AW-1:CH_AW]][weight_addr[CH_AW-1:0]] <= weight_data;
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array (4 neurons x 4 channels): vector table plus
// hand-written handshake, saturation, abort and weight-collision sequences.
module tb_lif_neuron_array;

  localparam int NN = 4;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_valid;
  logic        step_ready;
  logic [3:0]  spike_in;
  logic [4:0]  leak_shift;
  logic [15:0] threshold;
  logic [3:0]  refrac_len;
  logic        weight_wr;
  logic [3:0]  weight_addr;
  logic [7:0]  weight_data;
  logic [3:0]  spike_out;
  logic        spike_valid;
  logic [1:0]  vmem_rd_addr;
  logic [15:0] vmem_rd_data;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lif_neuron_array #(
    .N_CHANNEL(NC),
    .N_NEURON (NN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .spike_in    (spike_in),
    .leak_shift  (leak_shift),
    .threshold   (threshold),
    .refrac_len  (refrac_len),
    .weight_wr   (weight_wr),
    .weight_addr (weight_addr),
    .weight_data (weight_data),
    .spike_out   (spike_out),
    .spike_valid (spike_valid),
    .vmem_rd_addr(vmem_rd_addr),
    .vmem_rd_data(vmem_rd_data)
  );

  typedef struct {
    int          setup;
    bit          go;
    logic [3:0]  spk;
    logic [4:0]  leak;
    logic [15:0] thr;
    logic [3:0]  refr;
    logic [3:0]  exp_spk;
    int          probe;
    logic [15:0] exp_v;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    step_valid  = 1'b0;
    weight_wr   = 1'b0;
    spike_in    = '0;
    leak_shift  = '0;
    threshold   = '0;
    refrac_len  = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr_w(input int n, input int c, input logic [7:0] d);
    @(negedge clk);
    weight_wr   = 1'b1;
    weight_addr = {2'(n), 2'(c)};
    weight_data = d;
    @(negedge clk);
    weight_wr = 1'b0;
  endtask

  task automatic wait_sv(input string name);
    int budget = 0;
    while (!spike_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!spike_valid) check({name, " spike_valid timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_step(input logic [3:0] spk, input logic [4:0] leak, input logic [15:0] thr,
                          input logic [3:0] refr, output logic [3:0] so);
    int budget = 0;
    @(negedge clk);
    while (!step_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!step_ready) check("step_ready timeout", 32'd0, 32'd1);
    spike_in   = spk;
    leak_shift = leak;
    threshold  = thr;
    refrac_len = refr;
    step_valid = 1'b1;
    @(negedge clk);
    step_valid = 1'b0;
    wait_sv("run_step");
    so = spike_out;
  endtask

  task automatic read_v(input int n, output logic [15:0] v);
    @(negedge clk);
    vmem_rd_addr = 2'(n);
    @(negedge clk);
    v = vmem_rd_data;
  endtask

  task automatic setup(input int code);
    case (code)
      1: begin
        do_reset();
        for (int c = 0; c < NC; c++) wr_w(0, c, 8'd64);
      end
      2: begin
        do_reset();
        wr_w(1, 0, 8'd100);
      end
      3: begin
        do_reset();
        wr_w(3, 0, 8'd10);
        wr_w(3, 2, 8'hFD);
      end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  so;
    logic [15:0] v;
    logic        acc_b2;
    logic        saw_sv;

    // Basic fire; neurons without weights stay at zero.
    vecs[0]  = '{1, 1, 4'hF, 5'd16, 16'd200,  4'd0, 4'b0001, 0, 16'd0};
    vecs[1]  = '{0, 0, 4'h0, 5'd0,  16'd0,    4'd0, 4'b0000, 1, 16'd0};
    vecs[2]  = '{0, 0, 4'h0, 5'd0,  16'd0,    4'd0, 4'b0000, 2, 16'd0};
    vecs[3]  = '{0, 0, 4'h0, 5'd0,  16'd0,    4'd0, 4'b0000, 3, 16'd0};
    // Leak by half: 100, 150, 175.
    vecs[4]  = '{2, 1, 4'h1, 5'd1,  16'd1000, 4'd0, 4'b0000, 1, 16'd100};
    vecs[5]  = '{0, 1, 4'h1, 5'd1,  16'd1000, 4'd0, 4'b0000, 1, 16'd150};
    vecs[6]  = '{0, 1, 4'h1, 5'd1,  16'd1000, 4'd0, 4'b0000, 1, 16'd175};
    // Refractory length 2: fire pattern 1,0,0,1,0.
    vecs[7]  = '{1, 1, 4'hF, 5'd16, 16'd200,  4'd2, 4'b0001, 0, 16'd0};
    vecs[8]  = '{0, 1, 4'hF, 5'd16, 16'd200,  4'd2, 4'b0000, 0, 16'd0};
    vecs[9]  = '{0, 1, 4'hF, 5'd16, 16'd200,  4'd2, 4'b0000, 0, 16'd0};
    vecs[10] = '{0, 1, 4'hF, 5'd16, 16'd200,  4'd2, 4'b0001, 0, 16'd0};
    vecs[11] = '{0, 1, 4'hF, 5'd16, 16'd200,  4'd2, 4'b0000, 0, 16'd0};
    // S == threshold fires; negative current; leak_shift 0 restarts from I; shift 15.
    vecs[12] = '{3, 1, 4'h5, 5'd16, 16'd7,    4'd0, 4'b1000, 3, 16'd0};
    vecs[13] = '{0, 1, 4'h4, 5'd16, 16'd7,    4'd0, 4'b0000, 3, 16'hFFFD};
    vecs[14] = '{0, 1, 4'h1, 5'd0,  16'd100,  4'd0, 4'b0000, 3, 16'd10};
    vecs[15] = '{0, 1, 4'h1, 5'd0,  16'd100,  4'd0, 4'b0000, 3, 16'd10};
    vecs[16] = '{0, 1, 4'h1, 5'd15, 16'd100,  4'd0, 4'b0000, 3, 16'd20};

    rst          = 1'b1;
    step_valid   = 1'b0;
    weight_wr    = 1'b0;
    weight_addr  = '0;
    weight_data  = '0;
    spike_in     = '0;
    leak_shift   = '0;
    threshold    = '0;
    refrac_len   = '0;
    vmem_rd_addr = '0;
    repeat (2) @(negedge clk);
    check("reset step_ready", step_ready, 1);
    check("reset spike_out", spike_out, 0);
    check("reset spike_valid", spike_valid, 0);
    check("reset vmem_rd_data", vmem_rd_data, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      setup(vecs[i].setup);
      if (vecs[i].go) begin
        run_step(vecs[i].spk, vecs[i].leak, vecs[i].thr, vecs[i].refr, so);
        check($sformatf("vec%0d spike_out", i), so, vecs[i].exp_spk);
      end
      read_v(vecs[i].probe, v);
      check($sformatf("vec%0d V%0d", i, vecs[i].probe), v, vecs[i].exp_v);
    end

    // Saturation: neuron 2 sinks 512 per step and clamps at -32768.
    do_reset();
    for (int c = 0; c < NC; c++) wr_w(2, c, 8'h80);
    acc_b2 = 1'b0;
    for (int s = 1; s <= 66; s++) begin
      run_step(4'hF, 5'd16, 16'd0, 4'd0, so);
      acc_b2 = acc_b2 | so[2];
      if (s == 64) begin
        read_v(2, v);
        check("sat V2 after 64", v, 16'h8000);
      end
    end
    read_v(2, v);
    check("sat V2 after 66", v, 16'h8000);
    check("sat spike_out", so, 4'b1011);
    check("sat neuron2 never fired", acc_b2, 0);

    // Handshake: step_valid held high, accepts every NN+2 cycles.
    do_reset();
    @(negedge clk);
    spike_in   = 4'h0;
    leak_shift = 5'd16;
    threshold  = 16'h7FFF;
    refrac_len = '0;
    step_valid = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      check($sformatf("hs step_ready cyc%0d", cyc), step_ready, (cyc % (NN + 2)) == 0);
      check($sformatf("hs spike_valid cyc%0d", cyc), spike_valid,
            ((cyc % (NN + 2)) == 0) && (cyc > 0));
      @(negedge clk);
    end
    step_valid = 1'b0;

    // Abort mid-step at n=2.
    do_reset();
    wr_w(0, 0, 8'd5);
    @(negedge clk);
    vmem_rd_addr = 2'd0;
    spike_in     = 4'h1;
    leak_shift   = 5'd16;
    threshold    = 16'd200;
    refrac_len   = '0;
    step_valid   = 1'b1;
    @(negedge clk);
    step_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort V0 before rst", vmem_rd_data, 16'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    saw_sv = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw_sv = saw_sv | spike_valid;
    end
    check("abort no spike_valid", saw_sv, 0);
    check("abort step_ready", step_ready, 1);
    check("abort spike_out", spike_out, 0);
    for (int k = 0; k < NN; k++) begin
      read_v(k, v);
      check($sformatf("abort V%0d", k), v, 0);
    end

    // Weight write to neuron 1 during its own update.
    do_reset();
    wr_w(1, 0, 8'd50);
    @(negedge clk);
    spike_in   = 4'h1;
    leak_shift = 5'd16;
    threshold  = 16'd1000;
    refrac_len = '0;
    step_valid = 1'b1;
    @(negedge clk);
    step_valid = 1'b0;
    @(negedge clk);
    weight_wr   = 1'b1;
    weight_addr = {2'd1, 2'd0};
    weight_data = 8'd7;
    @(negedge clk);
    weight_wr = 1'b0;
    wait_sv("collision");
    read_v(1, v);
    check("collision V1 old weight", v, 16'd50);
    run_step(4'h1, 5'd16, 16'd1000, 4'd0, so);
    read_v(1, v);
    check("collision V1 new weight", v, 16'd57);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
